// File: rtl/block_spawner_if.sv
// Handshake bundle between the block spawner and the falling-block stage.
// The spawner owns the master side; the block stage (or a bench) owns the slave side.
interface block_spawner_if;
    logic       start;
    logic       block_hit;
    logic       block_end;
    logic       block_ready;
    logic [9:0] Block_X_Center;
    logic       block_restart;
    logic       level_done;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic [7:0] spawn_count;
    logic [1:0] lane;

    modport master (
        input  start, block_hit, block_end,
        output block_ready, Block_X_Center, block_restart, level_done,
        output hit_count, miss_count, spawn_count, lane
    );

    modport slave (
        output start, block_hit, block_end,
        input  block_ready, Block_X_Center, block_restart, level_done,
        input  hit_count, miss_count, spawn_count, lane
    );
endinterface

// File: rtl/block_spawner.sv
// Sequences block releases for one level: gap timing, LFSR lane choice,
// hit/miss bookkeeping and the restart pulse into the block stage.
module block_spawner #(
    parameter int unsigned NUM_BLOCKS = 20,
    parameter int unsigned GAP_FRAMES = 30,
    parameter logic [9:0]  LANE_X0    = 10'd200,
    parameter logic [9:0]  LANE_PITCH = 10'd80,
    parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
    input  logic frame_clk,
    input  logic Reset,
    block_spawner_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        FALL,
        RESTART,
        CHECK,
        DONE
    } state_t;

    localparam logic [7:0] GAP_RELOAD = 8'(GAP_FRAMES - 1);
    localparam logic [7:0] LEVEL_SIZE = 8'(NUM_BLOCKS);

    state_t     state_q, state_d;
    logic [7:0] gap_cnt_q, gap_cnt_d;
    logic [7:0] lfsr_q, lfsr_d;
    logic [1:0] lane_q, lane_d;
    logic [9:0] x_center_q, x_center_d;
    logic [7:0] hit_count_q, hit_count_d;
    logic [7:0] miss_count_q, miss_count_d;
    logic [7:0] spawn_count_q, spawn_count_d;
    logic       block_ready_q, block_ready_d;
    logic       block_restart_q, block_restart_d;
    logic       level_done_q, level_done_d;
    logic [7:0] lfsr_next;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q         <= IDLE;
            gap_cnt_q       <= 8'd0;
            lfsr_q          <= LFSR_SEED;
            lane_q          <= 2'd0;
            x_center_q      <= LANE_X0;
            hit_count_q     <= 8'd0;
            miss_count_q    <= 8'd0;
            spawn_count_q   <= 8'd0;
            block_ready_q   <= 1'b0;
            block_restart_q <= 1'b0;
            level_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            gap_cnt_q       <= gap_cnt_d;
            lfsr_q          <= lfsr_d;
            lane_q          <= lane_d;
            x_center_q      <= x_center_d;
            hit_count_q     <= hit_count_d;
            miss_count_q    <= miss_count_d;
            spawn_count_q   <= spawn_count_d;
            block_ready_q   <= block_ready_d;
            block_restart_q <= block_restart_d;
            level_done_q    <= level_done_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        gap_cnt_d       = gap_cnt_q;
        lfsr_d          = lfsr_q;
        lane_d          = lane_q;
        x_center_d      = x_center_q;
        hit_count_d     = hit_count_q;
        miss_count_d    = miss_count_q;
        spawn_count_d   = spawn_count_q;
        lfsr_next       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    hit_count_d   = 8'd0;
                    miss_count_d  = 8'd0;
                    spawn_count_d = 8'd0;
                    gap_cnt_d     = GAP_RELOAD;
                    state_d       = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q != 8'd0) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else begin
                    lfsr_d     = lfsr_next;
                    lane_d     = lfsr_next[1:0];
                    x_center_d = LANE_X0 + 10'(lfsr_next[1:0]) * LANE_PITCH;
                    state_d    = FALL;
                end
            end
            FALL: begin
                // A hit wins over a simultaneous end-of-screen, but the block stage still needs the restart.
                if (bus.block_hit) begin
                    hit_count_d   = hit_count_q + 8'd1;
                    spawn_count_d = spawn_count_q + 8'd1;
                    state_d       = bus.block_end ? RESTART : CHECK;
                end else if (bus.block_end) begin
                    miss_count_d  = miss_count_q + 8'd1;
                    spawn_count_d = spawn_count_q + 8'd1;
                    state_d       = RESTART;
                end
            end
            RESTART: begin
                state_d = CHECK;
            end
            CHECK: begin
                if (spawn_count_q == LEVEL_SIZE) begin
                    state_d = DONE;
                end else begin
                    gap_cnt_d = GAP_RELOAD;
                    state_d   = GAP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        block_ready_d   = (state_d == FALL);
        block_restart_d = (state_d == RESTART);
        level_done_d    = (state_d == DONE);
    end

    assign bus.block_ready    = block_ready_q;
    assign bus.Block_X_Center = x_center_q;
    assign bus.block_restart  = block_restart_q;
    assign bus.level_done     = level_done_q;
    assign bus.hit_count      = hit_count_q;
    assign bus.miss_count     = miss_count_q;
    assign bus.spawn_count    = spawn_count_q;
    assign bus.lane           = lane_q;

endmodule

// File: tb/tb_block_spawner.sv
// Directed bench for block_spawner: gap timing, lane sequence, hit/miss accounting,
// level completion, ignored inputs and asynchronous reset mid-level.
module tb_block_spawner;

    logic frame_clk = 1'b0;
    logic Reset;
    int   check_count = 0;
    int   pass_count  = 0;
    int   fail_count  = 0;
    logic [7:0] exp_lfsr;

    block_spawner_if bus();

    block_spawner #(
        .NUM_BLOCKS (6),
        .GAP_FRAMES (30),
        .LANE_X0    (10'd200),
        .LANE_PITCH (10'd80),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .bus       (bus)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d required %0d", tag, got, exp);
        end else begin
            pass_count++;
        end
    endtask

    task automatic stepFrame();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic hit_in, input logic end_in, input logic start_in);
        bus.block_hit = hit_in;
        bus.block_end = end_in;
        bus.start     = start_in;
        stepFrame();
        bus.block_hit = 1'b0;
        bus.block_end = 1'b0;
        bus.start     = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},   bus.block_ready, 0);
        checkOutput({tag, "_restart"}, bus.block_restart, 0);
        checkOutput({tag, "_done"},    bus.level_done, 0);
        checkOutput({tag, "_hit"},     bus.hit_count, 0);
        checkOutput({tag, "_miss"},    bus.miss_count, 0);
        checkOutput({tag, "_spawn"},   bus.spawn_count, 0);
        checkOutput({tag, "_lane"},    bus.lane, 0);
        checkOutput({tag, "_x"},       bus.Block_X_Center, 200);
    endtask

    // Drives one FALL-frame outcome and checks the counts right after that edge.
    task automatic resolveBlock(input logic hit_in, input logic end_in,
                                input int exp_hit, input int exp_miss,
                                input int exp_spawn, input int exp_restart);
        applyStimulus(hit_in, end_in, 1'b0);
        checkOutput("resolve_hit",     bus.hit_count, exp_hit);
        checkOutput("resolve_miss",    bus.miss_count, exp_miss);
        checkOutput("resolve_spawn",   bus.spawn_count, exp_spawn);
        checkOutput("resolve_ready",   bus.block_ready, 0);
        checkOutput("resolve_restart", bus.block_restart, exp_restart);
    endtask

    // Counts low frames (the current one included) until the next release and checks its lane.
    task automatic waitRelease(input int exp_lows);
        int lows = 1;
        int extra_restarts = 0;
        logic released = 1'b0;
        logic [1:0] exp_lane;
        for (int n = 0; n < 100 && !released; n++) begin
            stepFrame();
            if (bus.block_ready) released = 1'b1;
            else lows++;
            if (bus.block_restart) extra_restarts++;
        end
        checkOutput("release_seen", released, 1);
        checkOutput("release_low_frames", lows, exp_lows);
        checkOutput("release_extra_restart", extra_restarts, 0);
        exp_lfsr = lfsrStep(exp_lfsr);
        exp_lane = exp_lfsr[1:0];
        checkOutput("release_lane", bus.lane, exp_lane);
        checkOutput("release_x", bus.Block_X_Center, 200 + 80 * exp_lane);
    endtask

    initial begin
        Reset         = 1'b1;
        bus.start     = 1'b0;
        bus.block_hit = 1'b0;
        bus.block_end = 1'b0;
        exp_lfsr      = 8'hA5;
        stepFrame();
        stepFrame();
        checkResetValues("por");
        Reset = 1'b0;
        stepFrame();
        checkOutput("idle_ready", bus.block_ready, 0);

        // First release at E30; hit/end noise inside the gap must be ignored.
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("e0_ready", bus.block_ready, 0);
        for (int i = 1; i < 30; i++) begin
            applyStimulus(i >= 10 && i <= 12, i >= 10 && i <= 14, 1'b0);
            checkOutput($sformatf("gap_ready_e%0d", i), bus.block_ready, 0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0);
        exp_lfsr = lfsrStep(exp_lfsr);
        checkOutput("e30_ready", bus.block_ready, 1);
        checkOutput("e30_lane", bus.lane, 2);
        checkOutput("e30_x", bus.Block_X_Center, 360);
        checkOutput("gap_noise_hit", bus.hit_count, 0);
        checkOutput("gap_noise_miss", bus.miss_count, 0);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("fall_start_ready", bus.block_ready, 1);
        checkOutput("fall_start_spawn", bus.spawn_count, 0);
        checkOutput("fall_start_lane", bus.lane, 2);
        checkOutput("fall_start_done", bus.level_done, 0);

        // Miss: lfsr 0x4A -> 0x95, lane 1.
        resolveBlock(1'b0, 1'b1, 0, 1, 1, 1);
        waitRelease(32);
        checkOutput("blk2_x_const", bus.Block_X_Center, 280);

        resolveBlock(1'b1, 1'b1, 1, 1, 2, 1);
        waitRelease(32);
        resolveBlock(1'b1, 1'b0, 2, 1, 3, 0);
        waitRelease(31);
        resolveBlock(1'b0, 1'b1, 2, 2, 4, 1);
        waitRelease(32);
        resolveBlock(1'b1, 1'b0, 3, 2, 5, 0);
        waitRelease(31);
        checkOutput("blk6_x_const", bus.Block_X_Center, 440);

        // Last block of the level.
        resolveBlock(1'b0, 1'b1, 3, 3, 6, 1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("check_done", bus.level_done, 0);
        checkOutput("check_restart", bus.block_restart, 0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("done_flag", bus.level_done, 1);
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("done_hold", bus.level_done, 1);
        checkOutput("done_ready", bus.block_ready, 0);
        checkOutput("done_hit", bus.hit_count, 3);
        checkOutput("done_miss", bus.miss_count, 3);
        checkOutput("done_spawn", bus.spawn_count, 6);

        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("restart_done", bus.level_done, 0);
        checkOutput("restart_hit", bus.hit_count, 0);
        checkOutput("restart_miss", bus.miss_count, 0);
        checkOutput("restart_spawn", bus.spawn_count, 0);
        checkOutput("restart_ready", bus.block_ready, 0);
        waitRelease(30);
        for (int k = 1; k <= 5; k++) begin
            resolveBlock(1'b1, 1'b0, k, 0, k, 0);
            waitRelease(31);
        end

        // Asynchronous reset mid-FALL with five blocks resolved.
        checkOutput("pre_reset_spawn", bus.spawn_count, 5);
        #3;
        Reset = 1'b1;
        #1;
        checkResetValues("async");
        stepFrame();
        checkOutput("reset_hold_restart", bus.block_restart, 0);
        Reset    = 1'b0;
        exp_lfsr = 8'hA5;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitRelease(30);
        checkOutput("replay_lane0", bus.lane, 2);
        resolveBlock(1'b0, 1'b1, 0, 1, 1, 1);
        waitRelease(32);
        checkOutput("replay_lane1", bus.lane, 1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
